// File: rtl/memory_responder_if.sv
// Request/response bundle between the control unit (master) and the memory
// responder (slave): fetch strobe, data read/write strobes and completion pulses.
interface memory_responder_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 20
);
   logic              fetch;
   logic [ADDR_W-1:0] pc_addr;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] instruction;
   logic              instr_valid;
   logic [DATA_W-1:0] rdata;
   logic              rdata_valid;
   logic              write_done;
   logic              busy;
   logic              req_error;

   modport master (
      output fetch, pc_addr, mem_read, mem_write, addr, wdata,
      input  instruction, instr_valid, rdata, rdata_valid, write_done, busy, req_error
   );

   modport slave (
      input  fetch, pc_addr, mem_read, mem_write, addr, wdata,
      output instruction, instr_valid, rdata, rdata_valid, write_done, busy, req_error
   );
endinterface

// File: rtl/memory_responder.sv
// Memory responder: arbitrates PC fetches and data reads/writes onto a single-port
// word memory, inserts WAIT_STATES access cycles and returns one-cycle completion pulses.
module memory_responder #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 20,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst,
   memory_responder_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RESPOND = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      KIND_FETCH = 2'd0,
      KIND_READ  = 2'd1,
      KIND_WRITE = 2'd2
   } kind_t;

   localparam int         DEPTH     = 1 << ADDR_W;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   state_t            state_r;
   state_t            state_next_s;
   kind_t             kind_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic [3:0]        cnt_r;

   logic [DATA_W-1:0] mem_r [DEPTH];

   logic [DATA_W-1:0] instruction_r;
   logic [DATA_W-1:0] rdata_r;
   logic              instr_valid_r;
   logic              rdata_valid_r;
   logic              write_done_r;
   logic              busy_r;
   logic              req_error_r;

   logic              instr_valid_next_s;
   logic              rdata_valid_next_s;
   logic              write_done_next_s;
   logic              busy_next_s;
   logic              req_error_next_s;

   logic              data_req_s;
   logic              idle_open_s;
   logic              conflict_s;
   logic              accept_s;
   logic              commit_s;
   kind_t             req_kind_s;
   logic [ADDR_W-1:0] req_addr_s;
   kind_t             acc_kind_s;
   logic [ADDR_W-1:0] acc_addr_s;
   logic [DATA_W-1:0] acc_wdata_s;

   // Request decode; a completion pulse still on the bus blocks sampling so a
   // requester that drops on the pulse is never accepted twice.
   always_comb begin
      data_req_s  = bus.mem_read | bus.mem_write;
      idle_open_s = (state_r == ST_IDLE) &&
                    !(instr_valid_r || rdata_valid_r || write_done_r);
      conflict_s  = idle_open_s && bus.mem_read && bus.mem_write;
      accept_s    = idle_open_s && !conflict_s && (data_req_s || bus.fetch);
      if (bus.mem_write) begin
         req_kind_s = KIND_WRITE;
      end else if (bus.mem_read) begin
         req_kind_s = KIND_READ;
      end else begin
         req_kind_s = KIND_FETCH;
      end
      if (data_req_s) begin
         req_addr_s = bus.addr;
      end else begin
         req_addr_s = bus.pc_addr;
      end
   end

   // Access operands: live request when committing straight out of IDLE, else latched
   always_comb begin
      if (state_r == ST_IDLE) begin
         acc_kind_s  = req_kind_s;
         acc_addr_s  = req_addr_s;
         acc_wdata_s = bus.wdata;
      end else begin
         acc_kind_s  = kind_r;
         acc_addr_s  = addr_r;
         acc_wdata_s = wdata_r;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic and the commit strobe on entry to RESPOND
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (WAIT_INIT == 4'd0) begin
                  state_next_s = ST_RESPOND;
               end else begin
                  state_next_s = ST_ACCESS;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (cnt_r <= 4'd1) begin
               state_next_s = ST_RESPOND;
            end else begin
               state_next_s = ST_ACCESS;
            end
         end
         ST_RESPOND: state_next_s = ST_IDLE;
         default:    state_next_s = ST_IDLE;
      endcase
      commit_s = (state_r != ST_RESPOND) && (state_next_s == ST_RESPOND) && !rst;
   end

   // FSM output decode, registered one cycle later
   always_comb begin
      instr_valid_next_s = 1'b0;
      rdata_valid_next_s = 1'b0;
      write_done_next_s  = 1'b0;
      busy_next_s        = (state_r != ST_IDLE);
      req_error_next_s   = conflict_s;
      case (state_r)
         ST_RESPOND: begin
            case (kind_r)
               KIND_FETCH: instr_valid_next_s = 1'b1;
               KIND_READ:  rdata_valid_next_s = 1'b1;
               KIND_WRITE: write_done_next_s  = 1'b1;
               default:    instr_valid_next_s = 1'b0;
            endcase
         end
         default: instr_valid_next_s = 1'b0;
      endcase
   end

   // Request latch and wait-state counter
   always_ff @(posedge clk) begin
      if (rst) begin
         kind_r  <= KIND_FETCH;
         addr_r  <= {ADDR_W{1'b0}};
         wdata_r <= {DATA_W{1'b0}};
         cnt_r   <= 4'd0;
      end else if (accept_s) begin
         kind_r  <= req_kind_s;
         addr_r  <= req_addr_s;
         wdata_r <= bus.wdata;
         cnt_r   <= WAIT_INIT;
      end else if ((state_r == ST_ACCESS) && (cnt_r != 4'd0)) begin
         cnt_r   <= cnt_r - 4'd1;
      end
   end

   // Memory array write port; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (commit_s && (acc_kind_s == KIND_WRITE)) begin
         mem_r[acc_addr_s] <= acc_wdata_s;
      end
   end

   // Read capture into the holding registers on the commit edge
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_r       <= {DATA_W{1'b0}};
         instruction_r <= {DATA_W{1'b0}};
      end else if (commit_s && (acc_kind_s == KIND_READ)) begin
         rdata_r       <= mem_r[acc_addr_s];
      end else if (commit_s && (acc_kind_s == KIND_FETCH)) begin
         instruction_r <= mem_r[acc_addr_s];
      end
   end

   // Registered status and completion pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_valid_r <= 1'b0;
         rdata_valid_r <= 1'b0;
         write_done_r  <= 1'b0;
         busy_r        <= 1'b0;
         req_error_r   <= 1'b0;
      end else begin
         instr_valid_r <= instr_valid_next_s;
         rdata_valid_r <= rdata_valid_next_s;
         write_done_r  <= write_done_next_s;
         busy_r        <= busy_next_s;
         req_error_r   <= req_error_next_s;
      end
   end

   assign bus.instruction = instruction_r;
   assign bus.instr_valid = instr_valid_r;
   assign bus.rdata       = rdata_r;
   assign bus.rdata_valid = rdata_valid_r;
   assign bus.write_done  = write_done_r;
   assign bus.busy        = busy_r;
   assign bus.req_error   = req_error_r;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: one instance with one wait state, one with none.
module tb_memory_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   memory_responder_if #(.ADDR_W(10), .DATA_W(20)) b1 ();
   memory_responder_if #(.ADDR_W(10), .DATA_W(20)) b0 ();

   memory_responder #(.ADDR_W(10), .DATA_W(20), .WAIT_STATES(1)) u_dut1 (
      .clk(clk), .rst(rst), .bus(b1)
   );
   memory_responder #(.ADDR_W(10), .DATA_W(20), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst(rst), .bus(b0)
   );

   int total = 0;
   int bad   = 0;
   int n_wd, at_wd, n_rv, at_rv, n_iv, at_iv, n_busy, n_err;

   bit   use0 = 1'b0;
   logic m_wd, m_rv, m_iv, m_busy, m_err;

   always_comb begin
      if (use0) begin
         m_wd = b0.write_done; m_rv = b0.rdata_valid; m_iv = b0.instr_valid;
         m_busy = b0.busy; m_err = b0.req_error;
      end else begin
         m_wd = b1.write_done; m_rv = b1.rdata_valid; m_iv = b1.instr_valid;
         m_busy = b1.busy; m_err = b1.req_error;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs n sampled cycles from the acceptance edge; sample index i is the cycle after
   // that edge plus i. Requests are dropped the cycle after their pulse is seen.
   task automatic window(input bit sel0, input int n);
      bit dw, dr, df;
      use0 = sel0;
      n_wd = 0; at_wd = -1; n_rv = 0; at_rv = -1; n_iv = 0; at_iv = -1;
      n_busy = 0; n_err = 0;
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         dw = 1'b0; dr = 1'b0; df = 1'b0;
         if (m_wd) begin n_wd++; if (at_wd < 0) at_wd = i; dw = 1'b1; end
         if (m_rv) begin n_rv++; if (at_rv < 0) at_rv = i; dr = 1'b1; end
         if (m_iv) begin n_iv++; if (at_iv < 0) at_iv = i; df = 1'b1; end
         if (m_busy) n_busy++;
         if (m_err) n_err++;
         @(posedge clk); #1;
         if (sel0) begin
            if (dw) b0.mem_write = 1'b0;
            if (dr) b0.mem_read  = 1'b0;
            if (df) b0.fetch     = 1'b0;
         end else begin
            if (dw) b1.mem_write = 1'b0;
            if (dr) b1.mem_read  = 1'b0;
            if (df) b1.fetch     = 1'b0;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      b1.fetch = 1'b0; b1.pc_addr = 10'h000; b1.mem_read = 1'b0; b1.mem_write = 1'b0;
      b1.addr = 10'h000; b1.wdata = 20'h00000;
      b0.fetch = 1'b0; b0.pc_addr = 10'h000; b0.mem_read = 1'b0; b0.mem_write = 1'b0;
      b0.addr = 10'h000; b0.wdata = 20'h00000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_instruction", 32'(b1.instruction), 32'h0);
      check("rst_rdata",       32'(b1.rdata),       32'h0);
      check("rst_valids",      32'({b1.instr_valid, b1.rdata_valid, b1.write_done}), 32'h0);
      check("rst_busy_err",    32'({b1.busy, b1.req_error}), 32'h0);
      check("rst_busy0",       32'(b0.busy), 32'h0);

      // write 0x005 <- 0xABCDE
      @(posedge clk); #1;
      rst = 1'b0;
      b1.mem_write = 1'b1; b1.addr = 10'h005; b1.wdata = 20'hABCDE;
      window(1'b0, 6);
      check("wr_count",  32'(n_wd),   32'd1);
      check("wr_at",     32'(at_wd),  32'd2);
      check("wr_busy",   32'(n_busy), 32'd2);
      check("wr_others", 32'(n_rv + n_iv), 32'd0);

      // read back
      b1.mem_read = 1'b1; b1.addr = 10'h005;
      window(1'b0, 6);
      check("rd_count", 32'(n_rv),     32'd1);
      check("rd_at",    32'(at_rv),    32'd2);
      check("rd_data",  32'(b1.rdata), 32'hABCDE);

      // fetch same word, rdata must hold
      b1.fetch = 1'b1; b1.pc_addr = 10'h005;
      window(1'b0, 6);
      check("if_count",   32'(n_iv),           32'd1);
      check("if_at",      32'(at_iv),          32'd2);
      check("if_data",    32'(b1.instruction), 32'hABCDE);
      check("if_rd_hold", 32'(b1.rdata),       32'hABCDE);

      // seed 0x010 then fetch and read together: read wins, fetch follows 4 edges later
      b1.mem_write = 1'b1; b1.addr = 10'h010; b1.wdata = 20'h0F0F0;
      window(1'b0, 6);
      check("seed_count", 32'(n_wd), 32'd1);
      b1.fetch = 1'b1; b1.pc_addr = 10'h010; b1.mem_read = 1'b1; b1.addr = 10'h005;
      window(1'b0, 10);
      check("arb_rd_at", 32'(at_rv),          32'd2);
      check("arb_if_at", 32'(at_iv),          32'd6);
      check("arb_counts", 32'({n_rv[7:0], n_iv[7:0]}), 32'h0101);
      check("arb_if_data", 32'(b1.instruction), 32'h0F0F0);
      check("arb_rd_data", 32'(b1.rdata),       32'hABCDE);

      // read and write together for three IDLE cycles
      b1.mem_read = 1'b1; b1.mem_write = 1'b1; b1.addr = 10'h005; b1.wdata = 20'h11111;
      n_err = 0; n_wd = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (i == 2) begin b1.mem_read = 1'b0; b1.mem_write = 1'b0; end
         @(negedge clk);
         if (b1.req_error) n_err++;
         if (b1.write_done || b1.rdata_valid || b1.instr_valid) n_wd++;
      end
      check("err_cycles", 32'(n_err), 32'd3);
      check("err_no_pulse", 32'(n_wd), 32'd0);
      b1.mem_read = 1'b1; b1.addr = 10'h005;
      window(1'b0, 6);
      check("err_mem_kept", 32'(b1.rdata), 32'hABCDE);

      // last word, then a write aborted by reset during ACCESS
      b1.mem_write = 1'b1; b1.addr = 10'h3FF; b1.wdata = 20'hFFFFF;
      window(1'b0, 6);
      check("top_wr_count", 32'(n_wd), 32'd1);
      b1.mem_write = 1'b1; b1.addr = 10'h3FF; b1.wdata = 20'h00001;
      @(posedge clk); #1;
      rst = 1'b1; b1.mem_write = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy",  32'(b1.busy),  32'h0);
      check("abort_wd",    32'(b1.write_done), 32'h0);
      check("abort_rdata", 32'(b1.rdata), 32'h0);
      check("abort_instr", 32'(b1.instruction), 32'h0);
      window(1'b0, 4);
      check("abort_no_wd", 32'(n_wd + n_busy), 32'd0);
      b1.mem_read = 1'b1; b1.addr = 10'h3FF;
      window(1'b0, 6);
      check("abort_rd_data", 32'(b1.rdata), 32'hFFFFF);

      // zero wait states
      b0.mem_write = 1'b1; b0.addr = 10'h000; b0.wdata = 20'h12345;
      window(1'b1, 5);
      check("ws0_wr_at",   32'(at_wd),  32'd1);
      check("ws0_wr_cnt",  32'(n_wd),   32'd1);
      check("ws0_busy",    32'(n_busy), 32'd1);
      b0.mem_read = 1'b1; b0.addr = 10'h000;
      window(1'b1, 5);
      check("ws0_rd_at",   32'(at_rv),      32'd1);
      check("ws0_rd_data", 32'(b0.rdata),   32'h12345);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
